da2dac: RTL and testbench

- Serial transmitter for the Pmod DA2, which carries two DAC121S101 12-bit DACs on a shared SYNC/SCLK with separate data lines.
- It is the output-side counterpart of the AD1 receiver. A requester holds dacdav with two 12-bit codes, and the block shifts one 16-bit frame per channel, MSB first.
- It raises davdac when the frame is complete.
- It sits between the signal-generation logic and the JA/JB Pmod pins, clocked from the system-derived DAC clock.

---
 rtl/da2_pkg.sv | 25 ++
 rtl/da2sck.sv | 51 +++++
 rtl/da2dac.sv | 144 ++++++++++++++
 tb/tb_da2dac.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/da2_pkg.sv
// Shared types and constants for the Pmod DA2 (dual DAC121S101) transmitter.
package da2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2,
    ST_DONE  = 2'd3
  } da2_state_e;

  localparam int FRAME_BITS = 16;
  localparam int DATA_BITS  = 12;

  localparam logic [1:0] PD_NORMAL = 2'b00;
  localparam logic [1:0] PD_1K     = 2'b01;
  localparam logic [1:0] PD_100K   = 2'b10;
  localparam logic [1:0] PD_HIZ    = 2'b11;

  // DAC121S101 input word: two don't-care zeros, power-down mode, then the code.
  function automatic logic [FRAME_BITS-1:0] da2_frame(input logic [1:0]           pd,
                                                      input logic [DATA_BITS-1:0] code);
    return {2'b00, pd, code};
  endfunction

endpackage

// File: rtl/da2sck.sv
// SCLK divider: toggles dacsck every SCKDIV cycles while run is high and
// flags the cycle before each falling and rising transition.
module da2sck #(
  parameter int SCKDIV = 2
) (
  input  logic dacclk_i,
  input  logic dacreset_i,
  input  logic run_i,
  output logic dacsck_o,
  output logic fall_tick_o,
  output logic rise_tick_o
);

  localparam int CW = $clog2(SCKDIV + 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          sck_q, sck_d;
  logic          term_s;

  assign term_s      = run_i && (cnt_q == CW'(SCKDIV - 1));
  assign fall_tick_o = term_s && sck_q;
  assign rise_tick_o = term_s && !sck_q;
  assign dacsck_o    = sck_q;

  // Half-period counter; SCLK is parked high whenever the frame is not running.
  always_comb begin
    cnt_d = cnt_q;
    sck_d = sck_q;
    if (!run_i) begin
      cnt_d = {CW{1'b0}};
      sck_d = 1'b1;
    end else if (term_s) begin
      cnt_d = {CW{1'b0}};
      sck_d = !sck_q;
    end else begin
      cnt_d = cnt_q + CW'(1);
      sck_d = sck_q;
    end
  end

  always_ff @(posedge dacclk_i) begin
    if (dacreset_i) begin
      cnt_q <= {CW{1'b0}};
      sck_q <= 1'b1;
    end else begin
      cnt_q <= cnt_d;
      sck_q <= sck_d;
    end
  end

endmodule

// File: rtl/da2dac.sv
// Pmod DA2 serial transmitter: one 16-bit frame per DAC per request, MSB first,
// closed by a four-phase dacdav/davdac handshake.
module da2dac
  import da2_pkg::*;
#(
  parameter int         SCKDIV = 2,
  parameter logic [1:0] PDMODE = PD_NORMAL,
  parameter int         SYNCHI = 2
) (
  input  logic                 dacclk_i,
  input  logic                 dacreset_i,
  input  logic                 dacdav_i,
  input  logic [DATA_BITS-1:0] dac0data_i,
  input  logic [DATA_BITS-1:0] dac1data_i,
  output logic                 davdac_o,
  output logic                 busy_o,
  output logic                 dacsync_o,
  output logic                 dacsck_o,
  output logic                 dac0d_o,
  output logic                 dac1d_o
);

  localparam int GW = $clog2(SYNCHI + 1);

  da2_state_e            state_q, state_d;
  logic [FRAME_BITS-1:0] sh0_q, sh0_d, sh1_q, sh1_d;
  logic [3:0]            bit_q, bit_d;
  logic [GW-1:0]         gap_q, gap_d;
  logic                  sync_q, sync_d;
  logic                  dav_q, dav_d;
  logic                  busy_q, busy_d;
  logic                  run_s, fall_tick_s, rise_tick_s;

  assign run_s = (state_q == ST_SHIFT);

  da2sck #(.SCKDIV(SCKDIV)) u_sck (
    .dacclk_i   (dacclk_i),
    .dacreset_i (dacreset_i),
    .run_i      (run_s),
    .dacsck_o   (dacsck_o),
    .fall_tick_o(fall_tick_s),
    .rise_tick_o(rise_tick_s)
  );

  // The shift-register MSBs are the data pins; clearing them at frame end
  // returns both lines to 0. bit_q counts falling edges and wraps after 16.
  always_comb begin
    state_d = state_q;
    sh0_d   = sh0_q;
    sh1_d   = sh1_q;
    bit_d   = bit_q;
    gap_d   = gap_q;
    sync_d  = sync_q;
    dav_d   = dav_q;
    busy_d  = busy_q;
    case (state_q)
      ST_IDLE: begin
        if (dacdav_i) begin
          sh0_d   = da2_frame(PDMODE, dac0data_i);
          sh1_d   = da2_frame(PDMODE, dac1data_i);
          bit_d   = 4'd0;
          sync_d  = 1'b0;
          busy_d  = 1'b1;
          state_d = ST_SHIFT;
        end else begin
          sync_d  = 1'b1;
        end
      end
      ST_SHIFT: begin
        if (fall_tick_s) begin
          bit_d = bit_q + 4'd1;
        end else if (rise_tick_s) begin
          if (bit_q == 4'd0) begin
            sh0_d   = {FRAME_BITS{1'b0}};
            sh1_d   = {FRAME_BITS{1'b0}};
            sync_d  = 1'b1;
            gap_d   = {GW{1'b0}};
            state_d = ST_GAP;
          end else begin
            sh0_d   = {sh0_q[FRAME_BITS-2:0], 1'b0};
            sh1_d   = {sh1_q[FRAME_BITS-2:0], 1'b0};
          end
        end else begin
          bit_d = bit_q;
        end
      end
      ST_GAP: begin
        if (gap_q == GW'(SYNCHI - 1)) begin
          gap_d   = {GW{1'b0}};
          dav_d   = 1'b1;
          state_d = ST_DONE;
        end else begin
          gap_d   = gap_q + GW'(1);
        end
      end
      ST_DONE: begin
        if (!dacdav_i) begin
          dav_d   = 1'b0;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end else begin
          dav_d   = 1'b1;
        end
      end
      default: begin
        sh0_d   = {FRAME_BITS{1'b0}};
        sh1_d   = {FRAME_BITS{1'b0}};
        sync_d  = 1'b1;
        dav_d   = 1'b0;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge dacclk_i) begin
    if (dacreset_i) begin
      state_q <= ST_IDLE;
      sh0_q   <= {FRAME_BITS{1'b0}};
      sh1_q   <= {FRAME_BITS{1'b0}};
      bit_q   <= 4'd0;
      gap_q   <= {GW{1'b0}};
      sync_q  <= 1'b1;
      dav_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sh0_q   <= sh0_d;
      sh1_q   <= sh1_d;
      bit_q   <= bit_d;
      gap_q   <= gap_d;
      sync_q  <= sync_d;
      dav_q   <= dav_d;
      busy_q  <= busy_d;
    end
  end

  assign davdac_o  = dav_q;
  assign busy_o    = busy_q;
  assign dacsync_o = sync_q;
  assign dac0d_o   = sh0_q[FRAME_BITS-1];
  assign dac1d_o   = sh1_q[FRAME_BITS-1];

endmodule

// File: tb/tb_da2dac.sv
// Bench for da2dac: three configurations side by side, each frame decoded off
// the pins by a DAC-side monitor and compared to words/timing derived from the rules.
module tb_da2dac;

  localparam int         SA [3] = '{2, 2, 1};
  localparam int         YA [3] = '{2, 2, 1};
  localparam logic [1:0] PA [3] = '{2'b00, 2'b11, 2'b00};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        rst [3];
  logic        dav [3];
  logic [11:0] c0  [3];
  logic [11:0] c1  [3];
  logic davo [3], busyo [3], synco [3], scko [3], d0o [3], d1o [3];

  int n_cmp = 0;
  int n_err = 0;

  da2dac #(.SCKDIV(2), .PDMODE(2'b00), .SYNCHI(2)) u_dut0 (
    .dacclk_i(clk), .dacreset_i(rst[0]), .dacdav_i(dav[0]),
    .dac0data_i(c0[0]), .dac1data_i(c1[0]), .davdac_o(davo[0]), .busy_o(busyo[0]),
    .dacsync_o(synco[0]), .dacsck_o(scko[0]), .dac0d_o(d0o[0]), .dac1d_o(d1o[0]));

  da2dac #(.SCKDIV(2), .PDMODE(2'b11), .SYNCHI(2)) u_dut1 (
    .dacclk_i(clk), .dacreset_i(rst[1]), .dacdav_i(dav[1]),
    .dac0data_i(c0[1]), .dac1data_i(c1[1]), .davdac_o(davo[1]), .busy_o(busyo[1]),
    .dacsync_o(synco[1]), .dacsck_o(scko[1]), .dac0d_o(d0o[1]), .dac1d_o(d1o[1]));

  da2dac #(.SCKDIV(1), .PDMODE(2'b00), .SYNCHI(1)) u_dut2 (
    .dacclk_i(clk), .dacreset_i(rst[2]), .dacdav_i(dav[2]),
    .dac0data_i(c0[2]), .dac1data_i(c1[2]), .davdac_o(davo[2]), .busy_o(busyo[2]),
    .dacsync_o(synco[2]), .dacsck_o(scko[2]), .dac0d_o(d0o[2]), .dac1d_o(d1o[2]));

  // DAC-side monitor: what each DAC121S101 would shift in on SCLK falling edges.
  int          mframes [3];
  int          msl     [3];
  int          mfalls  [3];
  int          mfirst  [3];
  int          mlast   [3];
  int          mstab   [3];
  int          mper    [3];
  logic [15:0] mw0     [3];
  logic [15:0] mw1     [3];
  logic        psync [3], psck [3], pd0 [3], pd1 [3];

  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (synco[k] === 1'b0) begin
        if (psync[k] === 1'b1) begin
          mframes[k] <= mframes[k] + 1;
          msl[k]     <= 1;
          mfalls[k]  <= 0;
          mw0[k]     <= 16'h0000;
          mw1[k]     <= 16'h0000;
          mstab[k]   <= 0;
          mper[k]    <= 0;
        end else begin
          msl[k] <= msl[k] + 1;
          if (scko[k] === 1'b0 && psck[k] === 1'b1) begin
            mw0[k]    <= {mw0[k][14:0], d0o[k]};
            mw1[k]    <= {mw1[k][14:0], d1o[k]};
            mfalls[k] <= mfalls[k] + 1;
            mlast[k]  <= cyc;
            if (d0o[k] !== pd0[k] || d1o[k] !== pd1[k]) mstab[k] <= mstab[k] + 1;
            if (mfalls[k] == 0) mfirst[k] <= cyc;
            else if (cyc - mlast[k] != 2 * SA[k]) mper[k] <= mper[k] + 1;
          end
        end
      end
      psync[k] <= synco[k];
      psck[k]  <= scko[k];
      pd0[k]   <= d0o[k];
      pd1[k]   <= d1o[k];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // One request/handshake on instance k; chg_at/drop_at (falling-edge counts, -1 = off)
  // alter dac0data or drop dacdav mid-frame.
  task automatic run_frame(input int k, input logic [11:0] a0, input logic [11:0] a1,
                           input int hold, input int chg_at, input int drop_at, input string tg);
    int          t_req;
    int          fr0;
    bit          seen;
    bit          bad;
    logic [15:0] e0, e1;
    e0  = {2'b00, PA[k], a0};
    e1  = {2'b00, PA[k], a1};
    fr0 = mframes[k];
    @(negedge clk);
    c0[k] = a0; c1[k] = a1; dav[k] = 1'b1;
    t_req = cyc + 1;
    @(negedge clk);
    check({tg, ":start"}, {29'd0, synco[k], busyo[k], d0o[k]}, {29'd0, 1'b0, 1'b1, e0[15]});
    seen = 1'b0;
    for (int i = 0; i < 400 && !seen; i++) begin
      if (davo[k] === 1'b1) begin
        seen = 1'b1;
      end else begin
        if (mfalls[k] == chg_at) c0[k] = 12'hFFF;
        if (mfalls[k] == drop_at) dav[k] = 1'b0;
        @(negedge clk);
      end
    end
    check({tg, ":davdac_seen"}, 32'(seen), 32'd1);
    check({tg, ":latency"}, cyc - t_req + 1, 1 + 32 * SA[k] + YA[k]);
    check({tg, ":falls"}, mfalls[k], 16);
    check({tg, ":word0"}, mw0[k], e0);
    check({tg, ":word1"}, mw1[k], e1);
    check({tg, ":sync_low"}, msl[k], 32 * SA[k]);
    check({tg, ":first_fall"}, mfirst[k] - t_req, SA[k]);
    check({tg, ":sck_period"}, mper[k], 0);
    check({tg, ":data_stable"}, mstab[k], 0);
    if (dav[k] && hold > 0) begin
      bad = 1'b0;
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        if (davo[k] !== 1'b1 || busyo[k] !== 1'b1 || synco[k] !== 1'b1) bad = 1'b1;
      end
      check({tg, ":hold"}, 32'(bad), 32'd0);
    end
    dav[k] = 1'b0;
    @(negedge clk);
    check({tg, ":release"}, {30'd0, davo[k], busyo[k]}, 32'd0);
    check({tg, ":frames"}, mframes[k], fr0 + 1);
  endtask

  initial begin
    bit seen;
    bit bad;
    for (int k = 0; k < 3; k++) begin
      rst[k] = 1'b1; dav[k] = 1'b0; c0[k] = 12'h000; c1[k] = 12'h000;
    end
    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++)
      check($sformatf("reset%0d", k),
            {26'd0, synco[k], scko[k], d0o[k], d1o[k], davo[k], busyo[k]}, 32'b110000);
    for (int k = 0; k < 3; k++) rst[k] = 1'b0;
    repeat (2) @(negedge clk);

    run_frame(0, 12'hA5C, 12'h3F0, 100, -1, -1, "basic_hs");
    run_frame(0, 12'($urandom), 12'($urandom), 0, -1, -1, "rereq");
    run_frame(1, 12'h000, 12'hFFF, 2, -1, -1, "pd_lo_hi");
    run_frame(1, 12'hFFF, 12'h000, 0, -1, -1, "pd_hi_lo");
    run_frame(0, 12'h123, 12'h456, 1, 5, -1, "datachg");
    run_frame(0, 12'h321, 12'h654, 0, -1, 3, "early_drop");
    run_frame(2, 12'h9C3, 12'h1E7, 3, -1, -1, "fast");

    // Abort a frame at its eighth falling edge.
    @(negedge clk);
    c0[0] = 12'h456; c1[0] = 12'h9AB; dav[0] = 1'b1;
    repeat (2) @(negedge clk);
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      if (mfalls[0] >= 8) seen = 1'b1;
      else @(negedge clk);
    end
    check("rstmid:reach8", 32'(seen), 32'd1);
    rst[0] = 1'b1; dav[0] = 1'b0;
    @(negedge clk);
    check("rstmid:outs", {26'd0, synco[0], scko[0], d0o[0], d1o[0], davo[0], busyo[0]}, 32'b110000);
    rst[0] = 1'b0;
    bad = 1'b0;
    repeat (100) begin
      @(negedge clk);
      if (davo[0] !== 1'b0 || synco[0] !== 1'b1) bad = 1'b1;
    end
    check("rstmid:quiet", 32'(bad), 32'd0);
    check("rstmid:falls", mfalls[0], 8);
    run_frame(0, 12'h7FF, 12'h7FF, 0, -1, -1, "after_rst");

    // Reset and request in the same cycle: nothing may be latched.
    @(negedge clk);
    rst[1] = 1'b1; dav[1] = 1'b1; c0[1] = 12'hABC;
    @(negedge clk);
    rst[1] = 1'b0; dav[1] = 1'b0;
    check("rst_dav:edge", {30'd0, synco[1], busyo[1]}, 32'b10);
    @(negedge clk);
    check("rst_dav:after", {30'd0, synco[1], busyo[1]}, 32'b10);

    for (int r = 0; r < 4; r++)
      for (int k = 0; k < 3; k++)
        run_frame(k, 12'($urandom), 12'($urandom), int'($urandom_range(0, 5)), -1, -1,
                  $sformatf("rand%0d_%0d", r, k));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, compared %0d", n_cmp);
    $fatal(1, "watchdog expired");
  end

endmodule
